// File: rtl/exec_stage_mc_pkg.sv
// Shared definitions for the exec_stage_mc execute stage: ALU op codes,
// multiply/divide FSM state encoding and a small op-class helper.
// The multiply/divide unit is built only when EXEC_MULDIV_EN is defined.
package exec_stage_mc_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;
  localparam logic [3:0] ALU_DIVU = 4'd12;
  localparam logic [3:0] ALU_REM  = 4'd13;
  localparam logic [3:0] ALU_REMU = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } md_state_t;

  // True for the op codes handled by the iterative multiply/divide unit.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= ALU_MUL) && (op <= ALU_REMU);
  endfunction

endpackage

// File: rtl/exec_stage_mc_muldiv.sv
// Iterative multiply / restoring-divide unit for exec_stage_mc (built only
// under EXEC_MULDIV_EN). One shift-add or divide step per cycle. The RUN
// state performs XLEN-1 steps; the last step is evaluated combinationally
// in DONE, where the result is presented with done = 1 for one cycle.
// Divide-by-zero and signed overflow skip RUN and go straight to DONE.
module exec_muldiv_iter
  import exec_stage_mc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result,
  output md_state_t       state
);

  localparam int              CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  x_q, y_q, acc_q;
  logic             is_mul_q, is_rem_q, neg_q, corner_q;
  logic [XLEN-1:0]  corner_res_q;

  logic             op_signed, div_zero, div_ovf, corner;
  logic [XLEN-1:0]  mag_a, mag_b, corner_res;
  logic [XLEN:0]    r_sh, diff;
  logic             ge;
  logic [XLEN-1:0]  x_n, y_n, acc_n, raw, fin;

  // Decode of a new operation: magnitudes and corner-case results.
  always_comb begin
    op_signed  = (op == ALU_DIV) || (op == ALU_REM);
    div_zero   = (op != ALU_MUL) && (b == '0);
    div_ovf    = op_signed && (a == MOST_NEG) && (b == '1);
    corner     = div_zero || div_ovf;
    mag_a      = (op_signed && a[XLEN-1]) ? -a : a;
    mag_b      = (op_signed && b[XLEN-1]) ? -b : b;
    corner_res = '0;
    if (div_zero)
      corner_res = ((op == ALU_DIV) || (op == ALU_DIVU)) ? '1 : a;
    else if (div_ovf)
      corner_res = (op == ALU_DIV) ? a : '0;
  end

  // One iteration step: shift-add for MUL, restoring step for divides.
  always_comb begin
    r_sh  = {1'b0, acc_q[XLEN-1:0], x_q[XLEN-1]};
    r_sh  = {acc_q, x_q[XLEN-1]};
    diff  = r_sh - {1'b0, y_q};
    ge    = !diff[XLEN];
    if (is_mul_q) begin
      acc_n = acc_q + (y_q[0] ? x_q : '0);
      x_n   = x_q << 1;
      y_n   = y_q >> 1;
    end else begin
      acc_n = ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
      x_n   = {x_q[XLEN-2:0], ge};
      y_n   = y_q;
    end
    raw = (is_mul_q || is_rem_q) ? acc_n : x_n;
    fin = neg_q ? -raw : raw;
  end

  // FSM state register; reset and flush both abandon any partial result.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = corner ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q == CNT_W'(2)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: capture on start, iterate while in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      acc_q        <= '0;
      is_mul_q     <= 1'b0;
      is_rem_q     <= 1'b0;
      neg_q        <= 1'b0;
      corner_q     <= 1'b0;
      corner_res_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      cnt_q        <= CNT_INIT;
      x_q          <= (op == ALU_MUL) ? a : mag_a;
      y_q          <= (op == ALU_MUL) ? b : mag_b;
      acc_q        <= '0;
      is_mul_q     <= (op == ALU_MUL);
      is_rem_q     <= (op == ALU_REM) || (op == ALU_REMU);
      neg_q        <= ((op == ALU_DIV) && (a[XLEN-1] ^ b[XLEN-1])) ||
                      ((op == ALU_REM) && a[XLEN-1]);
      corner_q     <= corner;
      corner_res_q <= corner_res;
    end else if (state_q == ST_RUN) begin
      cnt_q <= cnt_q - 1'b1;
      x_q   <= x_n;
      y_q   <= y_n;
      acc_q <= acc_n;
    end
  end

  assign done   = (state_q == ST_DONE);
  assign result = corner_q ? corner_res_q : fin;
  assign state  = state_q;

endmodule

// File: rtl/exec_stage_mc.sv
// Registered execute stage with valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid && ready;
// a producer holds valid and its data stable until that edge, and the
// output side keeps out_* stable while out_valid && !out_ready.
// Single-cycle ALU ops have latency 1. With EXEC_MULDIV_EN defined,
// MUL/DIV/DIVU/REM/REMU run on exec_muldiv_iter; otherwise they execute
// as ADD.
module exec_stage_mc
  import exec_stage_mc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SB_W = 8,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic            in_alu_src,
  input  logic [XLEN-1:0] in_src_a,
  input  logic [XLEN-1:0] in_src_b,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_imm_u,
  input  logic [XLEN-1:0] in_pc_branch,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [RD_W-1:0] in_rd,
  input  logic [SB_W-1:0] in_sb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_neg,
  output logic [XLEN-1:0] out_imm_u,
  output logic [XLEN-1:0] out_pc_branch,
  output logic [XLEN-1:0] out_pc_plus4,
  output logic [RD_W-1:0] out_rd,
  output logic [SB_W-1:0] out_sb
);

  localparam int SH_W = $clog2(XLEN);

  logic [XLEN-1:0] op_b, alu_res;
  logic [SH_W-1:0] shamt;
  logic            accept, accept_single;
  md_state_t       md_state;
  logic            md_done;
  logic [XLEN-1:0] md_result;
  logic [XLEN-1:0] pend_imm_u, pend_pc_branch, pend_pc_plus4;
  logic [RD_W-1:0] pend_rd;
  logic [SB_W-1:0] pend_sb;

  logic [XLEN-1:0] res_next, imm_u_next, pc_branch_next, pc_plus4_next;
  logic [RD_W-1:0] rd_next;
  logic [SB_W-1:0] sb_next;

  // Single-cycle ALU; unknown op codes behave as ADD.
  always_comb begin
    op_b  = in_alu_src ? in_imm : in_src_b;
    shamt = op_b[SH_W-1:0];
    case (in_op)
      ALU_ADD:  alu_res = in_src_a + op_b;
      ALU_SUB:  alu_res = in_src_a - op_b;
      ALU_AND:  alu_res = in_src_a & op_b;
      ALU_OR:   alu_res = in_src_a | op_b;
      ALU_XOR:  alu_res = in_src_a ^ op_b;
      ALU_SLL:  alu_res = in_src_a << shamt;
      ALU_SRL:  alu_res = in_src_a >> shamt;
      ALU_SRA:  alu_res = $signed(in_src_a) >>> shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(in_src_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, in_src_a < op_b};
      default:  alu_res = in_src_a + op_b;
    endcase
  end

  assign in_ready = rst_n && (md_state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;

`ifdef EXEC_MULDIV_EN
  logic md_start;

  assign md_start      = accept && is_muldiv(in_op);
  assign accept_single = accept && !is_muldiv(in_op);

  exec_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (md_start),
    .op     (in_op),
    .a      (in_src_a),
    .b      (op_b),
    .done   (md_done),
    .result (md_result),
    .state  (md_state)
  );

  // Hold the pass-through fields of the multi-cycle op until it completes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_imm_u     <= '0;
      pend_pc_branch <= '0;
      pend_pc_plus4  <= '0;
      pend_rd        <= '0;
      pend_sb        <= '0;
    end else if (md_start) begin
      pend_imm_u     <= in_imm_u;
      pend_pc_branch <= in_pc_branch;
      pend_pc_plus4  <= in_pc_plus4;
      pend_rd        <= in_rd;
      pend_sb        <= in_sb;
    end
  end
`else
  assign accept_single  = accept;
  assign md_state       = ST_IDLE;
  assign md_done        = 1'b0;
  assign md_result      = '0;
  assign pend_imm_u     = '0;
  assign pend_pc_branch = '0;
  assign pend_pc_plus4  = '0;
  assign pend_rd        = '0;
  assign pend_sb        = '0;
`endif

  // Select what the output register loads: a finished multi-cycle op or
  // the instruction being accepted this cycle.
  always_comb begin
    res_next       = md_done ? md_result      : alu_res;
    imm_u_next     = md_done ? pend_imm_u     : in_imm_u;
    pc_branch_next = md_done ? pend_pc_branch : in_pc_branch;
    pc_plus4_next  = md_done ? pend_pc_plus4  : in_pc_plus4;
    rd_next        = md_done ? pend_rd        : in_rd;
    sb_next        = md_done ? pend_sb        : in_sb;
  end

  // Output register: flush kills, a new result replaces the old one in
  // the same edge it is consumed, otherwise a consumed result drops valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_zero      <= 1'b0;
      out_neg       <= 1'b0;
      out_imm_u     <= '0;
      out_pc_branch <= '0;
      out_pc_plus4  <= '0;
      out_rd        <= '0;
      out_sb        <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (md_done || accept_single) begin
      out_valid     <= 1'b1;
      out_result    <= res_next;
      out_zero      <= (res_next == '0);
      out_neg       <= res_next[XLEN-1];
      out_imm_u     <= imm_u_next;
      out_pc_branch <= pc_branch_next;
      out_pc_plus4  <= pc_plus4_next;
      out_rd        <= rd_next;
      out_sb        <= sb_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Self-checking bench for exec_stage_mc. Works with and without
// EXEC_MULDIV_EN; the reference model follows the same macro.
`timescale 1ns/1ps
module tb_exec_stage_mc;

  localparam int XLEN = 32;
  localparam int SB_W = 8;
  localparam int RD_W = 5;
  localparam int W    = 4*XLEN + 2 + RD_W + SB_W;
`ifdef EXEC_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam logic [XLEN-1:0] MOST_NEG = 32'h8000_0000;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4,  OP_SLL = 4'd5,  OP_SRL = 4'd6,  OP_SRA = 4'd7;
  localparam logic [3:0] OP_SLT = 4'd8,  OP_SLTU = 4'd9, OP_MUL = 4'd10, OP_DIV = 4'd11;
  localparam logic [3:0] OP_DIVU = 4'd12, OP_REM = 4'd13, OP_REMU = 4'd14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_op = '0;
  logic            in_alu_src = 1'b0;
  logic [XLEN-1:0] in_src_a = '0, in_src_b = '0, in_imm = '0;
  logic [XLEN-1:0] in_imm_u = '0, in_pc_branch = '0, in_pc_plus4 = '0;
  logic [RD_W-1:0] in_rd = '0;
  logic [SB_W-1:0] in_sb = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_result, out_imm_u, out_pc_branch, out_pc_plus4;
  logic            out_zero, out_neg;
  logic [RD_W-1:0] out_rd;
  logic [SB_W-1:0] out_sb;

  exec_stage_mc #(.XLEN(XLEN), .SB_W(SB_W), .RD_W(RD_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_alu_src(in_alu_src), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_imm(in_imm), .in_imm_u(in_imm_u), .in_pc_branch(in_pc_branch),
    .in_pc_plus4(in_pc_plus4), .in_rd(in_rd), .in_sb(in_sb),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_neg(out_neg), .out_imm_u(out_imm_u),
    .out_pc_branch(out_pc_branch), .out_pc_plus4(out_pc_plus4),
    .out_rd(out_rd), .out_sb(out_sb)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_result(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [2*XLEN-1:0] prod;
    sa = a;
    sb = b;
    prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    case (op)
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return sa >>> b[4:0];
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_MUL:  return MD_EN ? prod[XLEN-1:0] : a + b;
      OP_DIV: begin
        if (!MD_EN) return a + b;
        if (b == 0) return '1;
        if (a == MOST_NEG && b == '1) return a;
        return sa / sb;
      end
      OP_DIVU: begin
        if (!MD_EN) return a + b;
        if (b == 0) return '1;
        return a / b;
      end
      OP_REM: begin
        if (!MD_EN) return a + b;
        if (b == 0) return a;
        if (a == MOST_NEG && b == '1) return '0;
        return sa % sb;
      end
      OP_REMU: begin
        if (!MD_EN) return a + b;
        if (b == 0) return a;
        return a % b;
      end
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    if (MD_EN && op == OP_MUL) return XLEN + 1;
    if (MD_EN && op >= OP_DIV && op <= OP_REMU) begin
      if (b == 0) return 2;
      if ((op == OP_DIV || op == OP_REM) && a == MOST_NEG && b == '1) return 2;
      return XLEN + 1;
    end
    return 1;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           cyc_q[$];
  int           lat_q[$];
  bit           seen = 1'b0;

  // Handshakes complete at the next rising edge; decide them here.
  always @(negedge clk) begin
    logic [W-1:0]    e;
    logic [XLEN-1:0] b_eff, r;
    if (rst_n) begin
      if (flush) begin
        exp_q.delete();
        cyc_q.delete();
        lat_q.delete();
        seen = 1'b0;
      end else begin
        if (exp_q.size() == 0) begin
          check("idle_valid", out_valid, 0);
        end else if (out_valid) begin
          e = exp_q[0];
          if (!seen) begin
            check("latency", cyc - cyc_q[0], lat_q[0]);
            seen = 1'b1;
          end
          check("result",    out_result,    e[W-1 -: XLEN]);
          check("zero",      out_zero,      e[W-1-XLEN]);
          check("neg",       out_neg,       e[W-2-XLEN]);
          check("rd",        out_rd,        e[W-3-XLEN -: RD_W]);
          check("sb",        out_sb,        e[W-3-XLEN-RD_W -: SB_W]);
          check("imm_u",     out_imm_u,     e[3*XLEN-1 -: XLEN]);
          check("pc_branch", out_pc_branch, e[2*XLEN-1 -: XLEN]);
          check("pc_plus4",  out_pc_plus4,  e[XLEN-1:0]);
          if (!out_ready) begin
            check("hold_ready", in_ready, 0);
          end else begin
            void'(exp_q.pop_front());
            void'(cyc_q.pop_front());
            void'(lat_q.pop_front());
            seen = 1'b0;
          end
        end
        if (in_valid && in_ready) begin
          b_eff = in_alu_src ? in_imm : in_src_b;
          r = ref_result(in_op, in_src_a, b_eff);
          exp_q.push_back({r, r == 0, r[XLEN-1], in_rd, in_sb,
                           in_imm_u, in_pc_branch, in_pc_plus4});
          cyc_q.push_back(cyc);
          lat_q.push_back(ref_latency(in_op, in_src_a, b_eff));
        end
      end
    end
  end

  // ---------------- downstream ready ----------------
  bit rand_ready = 1'b0;
  bit forced_ready = 1'b1;
  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] op, input logic src,
                      input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] imm);
    bit acc = 1'b0;
    in_op        = op;
    in_alu_src   = src;
    in_src_a     = a;
    in_src_b     = b;
    in_imm       = imm;
    in_imm_u     = $urandom;
    in_pc_branch = $urandom;
    in_pc_plus4  = $urandom;
    in_rd        = RD_W'($urandom);
    in_sb        = SB_W'($urandom);
    in_valid     = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("accept", acc, 1);
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return MOST_NEG;
      2:       return '1;
      3:       return XLEN'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int c0;
    // Reset held with an instruction offered.
    in_valid = 1'b1; in_op = OP_ADD; in_src_a = 5; in_src_b = 7;
    in_rd = 5'd3; in_sb = 8'h5A; in_pc_plus4 = 32'h104;
    repeat (3) step();
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready",   in_ready,   0);
      check("rst_out_valid",  out_valid,  0);
      check("rst_out_result", out_result, 0);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);
    step();                                     // ADD 5+7 accepted here

    // Back-to-back stream.
    c0 = cyc;
    send(OP_SUB,  1'b0, 32'd3,       32'd5, 32'd0);
    send(OP_SRA,  1'b1, MOST_NEG,    32'd0, 32'd4);
    send(OP_SLTU, 1'b0, 32'd1,       32'd2, 32'd0);
    check("stream_rate", cyc - c0, 3);
    drain(10);

    // Output stall: result must stay put, input side blocked.
    forced_ready = 1'b0;
    send(OP_SUB, 1'b0, 32'd9, 32'd9, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("hold_zero",  out_zero,  1);
      check("hold_valid", out_valid, 1);
    end
    step();
    forced_ready = 1'b1;
    drain(10);

    // Multiply/divide and their corner cases.
    send(OP_DIV,  1'b0, 32'hFFFF_FFF9, 32'd2,      32'd0); drain(100);
    send(OP_REM,  1'b0, 32'hFFFF_FFF9, 32'd2,      32'd0); drain(100);
    send(OP_DIVU, 1'b0, 32'd10,        32'd0,      32'd0); drain(100);
    send(OP_DIV,  1'b0, MOST_NEG,      '1,         32'd0); drain(100);
    send(OP_REMU, 1'b0, 32'd10,        32'd0,      32'd0); drain(100);
    send(OP_MUL,  1'b0, 32'd3,         32'd4,      32'd0); drain(100);

    // Flush in the middle of a MUL.
    send(OP_MUL, 1'b0, 32'd3, 32'd4, 32'd0);
    repeat (8) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("ready_after_flush", in_ready, 1);
    repeat (40) begin
      @(negedge clk);
      check("flush_no_valid", out_valid, 0);
    end
    step();
    send(OP_ADD, 1'b0, 32'd1, 32'd1, 32'd0);
    drain(10);

    // Flush of a held single-cycle result.
    forced_ready = 1'b0;
    step();
    send(OP_XOR, 1'b0, 32'h1234, 32'h00FF, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_held", out_valid, 0);
    step();
    forced_ready = 1'b1;

    // Randomized traffic with random downstream back-pressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        flush = 1'b1;
        step();
        flush = 1'b0;
      end
      send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           rand_operand(), rand_operand(), rand_operand());
    end
    rand_ready = 1'b0;
    forced_ready = 1'b1;
    drain(200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
